prog_loader: RTL and testbench

- Boot-time program loader directly upstream of the cpu: fills instruction memory from a byte stream (UART receiver), then releases the cpu from reset.
- Holds the cpu in reset while loading.
- Assembles little-endian 32-bit words and writes them to consecutive imem word addresses.
- Verifies an 8-bit additive checksum before starting the cpu.
- Supports a reload request without a global reset.

---
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a count/data/checksum byte stream, fills
// instruction memory with little-endian words, then releases the cpu from reset.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wd,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    RX_COUNT = 3'd0,
    RX_DATA  = 3'd1,
    RX_CSUM  = 3'd2,
    RUN      = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] count_r;
  logic [23:0] word_r;
  logic [7:0]  csum_r;

  logic        take_s;
  logic [31:0] full_count_s;
  logic        last_word_s;

  // Checksum accumulates data bytes with 8-bit wrap.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign take_s       = rx_valid & rx_ready;
  // The 4th count byte completes the word; earlier bytes sit in count_r[31:8].
  assign full_count_s = {rx_data, count_r[31:8]};
  assign last_word_s  = ((32'(words_loaded) + 32'd1) == count_r);

  // Loader state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RX_COUNT;
      byte_cnt_r   <= 2'd0;
      count_r      <= 32'd0;
      word_r       <= 24'd0;
      csum_r       <= 8'd0;
      rx_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wd      <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        RX_COUNT: begin
          if (take_s) begin
            count_r    <= full_count_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (full_count_s > 32'(IMEM_DEPTH)) begin
                state_r  <= ERROR;
                rx_ready <= 1'b0;
                error    <= 1'b1;
              end else if (full_count_s == 32'd0) begin
                state_r <= RX_CSUM;
              end else begin
                state_r <= RX_DATA;
              end
            end
          end
        end
        RX_DATA: begin
          if (take_s) begin
            csum_r     <= csum_add(csum_r, rx_data);
            word_r     <= {rx_data, word_r[23:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              imem_we      <= 1'b1;
              imem_waddr   <= words_loaded[ADDR_WIDTH-1:0];
              imem_wd      <= {rx_data, word_r};
              words_loaded <= words_loaded + 1'b1;
              if (last_word_s) begin
                state_r <= RX_CSUM;
              end
            end
          end
        end
        RX_CSUM: begin
          if (take_s) begin
            rx_ready <= 1'b0;
            if (rx_data == csum_r) begin
              state_r <= RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ERROR;
              error   <= 1'b1;
            end
          end
        end
        RUN, ERROR: begin
          if (reload) begin
            state_r      <= RX_COUNT;
            byte_cnt_r   <= 2'd0;
            count_r      <= 32'd0;
            word_r       <= 24'd0;
            csum_r       <= 8'd0;
            rx_ready     <= 1'b1;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: begin
          state_r  <= ERROR;
          rx_ready <= 1'b0;
          cpu_rst  <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: streams loads into the DUT and
// compares imem writes and final status against a stream-level reference model.
module tb_prog_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wd;
  logic          cpu_rst;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [39:0] obs_q[$];
  logic [31:0] ld_words[$];
  bit          reload_noise = 1'b0;

  prog_loader #(.DATA_WIDTH(32), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wd(imem_wd),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write seen by the imem.
  always @(negedge clk) if (imem_we === 1'b1) obs_q.push_back({imem_waddr, imem_wd});

  function automatic logic [7:0] word_sum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    reload   = reload_noise ? 1'($urandom_range(1, 0)) : 1'b0;
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rx_ready_during_load: got %b exp 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reload   = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    checks++;
    if ({cpu_rst, rx_ready, done, error, words_loaded} !== {1'b1, 1'b1, 1'b0, 1'b0, 9'd0}) begin
      failures++;
      $display("FAIL reload: got cpu_rst=%b rx_ready=%b done=%b error=%b wl=%0d exp 1 1 0 0 0",
               cpu_rst, rx_ready, done, error, words_loaded);
    end
  endtask

  // Streams count, ld_words and csum; checks writes and final status against the model.
  task automatic run_load(input string name, input logic [31:0] n, input logic [7:0] csum,
                          input int max_gap);
    logic [7:0]  sum;
    logic [39:0] exp_q[$];
    logic [7:0]  a;
    bit          ok;
    sum = 8'd0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], max_gap);
    if (n > 32'(DEPTH)) begin
      checks++;
      if ({error, done, cpu_rst, rx_ready, words_loaded} !== {1'b1, 1'b0, 1'b1, 1'b0, 9'd0}) begin
        failures++;
        $display("FAIL %s_overflow: got error=%b done=%b cpu_rst=%b rx_ready=%b wl=%0d exp 1 0 1 0 0",
                 name, error, done, cpu_rst, rx_ready, words_loaded);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (obs_q.size() !== 0) begin
        failures++;
        $display("FAIL %s_overflow_writes: got %0d writes exp 0", name, obs_q.size());
      end
      return;
    end
    for (int k = 0; k < ld_words.size(); k++) begin
      for (int i = 0; i < 4; i++) send_byte(ld_words[k][8*i +: 8], max_gap);
      sum = sum + word_sum(ld_words[k]);
      a = k[7:0];
      exp_q.push_back({a, ld_words[k]});
    end
    checks++;
    if (cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL %s_cpu_rst_before_csum: got %b exp 1", name, cpu_rst);
    end
    send_byte(csum, max_gap);
    ok = (csum == sum);
    checks++;
    if ({cpu_rst, done, error, rx_ready, words_loaded} !== {!ok, ok, !ok, 1'b0, n[8:0]}) begin
      failures++;
      $display("FAIL %s_status: got cpu_rst=%b done=%b error=%b rx_ready=%b wl=%0d exp %b %b %b 0 %0d",
               name, cpu_rst, done, error, rx_ready, words_loaded, !ok, ok, !ok, n);
    end
    // Bytes offered while not ready must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({cpu_rst, done, error, rx_ready, words_loaded} !== {!ok, ok, !ok, 1'b0, n[8:0]}) begin
      failures++;
      $display("FAIL %s_idle_hold: got cpu_rst=%b done=%b error=%b rx_ready=%b wl=%0d",
               name, cpu_rst, done, error, rx_ready, words_loaded);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_write_count: got %0d exp %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL %s_write%0d: got addr=%h data=%h exp addr=%h data=%h",
                   name, k, obs_q[k][39:32], obs_q[k][31:0], exp_q[k][39:32], exp_q[k][31:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_waddr, imem_wd, cpu_rst, done, error, words_loaded} !==
        {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h cpu_rst=%b done=%b err=%b wl=%0d",
               rx_ready, imem_we, imem_waddr, imem_wd, cpu_rst, done, error, words_loaded);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ld_words = '{32'h0000_0013, 32'h00A0_0093};
    run_load("basic", 32'd2, 8'h46, 0);
  endtask

  task automatic test_bad_csum();
    pulse_reload();
    ld_words = '{32'h0000_0013, 32'h00A0_0093};
    run_load("bad_csum", 32'd2, 8'h47, 0);
  endtask

  task automatic test_overflow();
    pulse_reload();
    ld_words.delete();
    run_load("overflow", 32'h0000_0101, 8'h00, 0);
  endtask

  task automatic test_zero_then_reload();
    pulse_reload();
    ld_words.delete();
    run_load("zero", 32'd0, 8'h00, 0);
    pulse_reload();
    ld_words = '{32'hDEAD_BEEF};
    run_load("one_word", 32'd1, 8'h38, 0);
  endtask

  task automatic test_gaps();
    pulse_reload();
    ld_words = '{32'h0000_0013, 32'h00A0_0093};
    run_load("gaps", 32'd2, 8'h46, 5);
  endtask

  task automatic test_rst_midload();
    logic [7:0] s[6];
    pulse_reload();
    obs_q.delete();
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, imem_we, imem_waddr, imem_wd, cpu_rst, done, error, words_loaded} !==
        {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
      failures++;
      $display("FAIL rst_midload: got rdy=%b we=%b a=%h d=%h cpu_rst=%b done=%b err=%b wl=%0d",
               rx_ready, imem_we, imem_waddr, imem_wd, cpu_rst, done, error, words_loaded);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL rst_midload_writes: got %0d exp 0", obs_q.size());
    end
    ld_words = '{32'h0000_0013, 32'h00A0_0093};
    run_load("after_rst", 32'd2, 8'h46, 0);
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [7:0]  sum;
    reload_noise = 1'b1;
    for (int it = 0; it < 8; it++) begin
      pulse_reload();
      n = 32'($urandom_range(12, 1));
      sum = 8'd0;
      ld_words.delete();
      for (int k = 0; k < int'(n); k++) begin
        ld_words.push_back($urandom);
        sum = sum + word_sum(ld_words[k]);
      end
      if ($urandom_range(3, 0) == 0) sum = sum + 8'($urandom_range(255, 1));
      run_load("random", n, sum, 3);
    end
    reload_noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_overflow();
    test_zero_then_reload();
    test_gaps();
    test_rst_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
